// File: rtl/wave_dma_pkg.sv
// Shared definitions for the wave DMA arbiter: FSM encoding, line geometry
// and the byte-lane extraction helper.
package wave_dma_pkg;

   localparam int LINE_W    = 64;
   localparam int LANE_BITS = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   // Pick byte 'lane' out of a little-endian 64-bit line.
   function automatic logic [7:0] lane_sel(input logic [LINE_W-1:0]    line,
                                           input logic [LANE_BITS-1:0] lane);
      return line[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/wave_dma_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping around, returned both one-hot and as an index.
module rr_arbiter #(
   parameter int NCH = 8,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [NCH-1:0] req_i,
   input  logic [IW-1:0]  ptr_i,
   output logic [NCH-1:0] gnt_o,
   output logic [IW-1:0]  idx_o,
   output logic           any_o
);

   logic [IW-1:0] cand;

   // Scan channels starting at the pointer; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int i = 0; i < NCH; i++) begin
         cand = IW'((int'(ptr_i) + i) % NCH);
         if (!any_o && req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wave_dma_arbiter.sv
// Shares one 64-bit DDR read port between NCH byte-fetch channels. Each
// channel owns an 8-byte line buffer so sequential bytes are served locally;
// only one DDR read is ever outstanding.
module wave_dma_arbiter
   import wave_dma_pkg::*;
#(
   parameter int NCH     = 8,
   parameter int AW      = 28,
   parameter int TIMEOUT = 1000
) (
   input  logic              I_CLK,
   input  logic              I_RSTn,
   input  logic [NCH-1:0]    I_REQ,
   input  logic [NCH*AW-1:0] I_ADDR,
   input  logic              I_FLUSH,
   output logic [NCH-1:0]    O_ACK,
   output logic [7:0]        O_DATA,
   output logic              O_ERR,
   output logic              O_DDR_RD,
   output logic [AW-1:0]     O_DDR_ADDR,
   input  logic              I_DDR_BUSY,
   input  logic [63:0]       I_DDR_DOUT,
   input  logic              I_DDR_DOUT_READY
);

   localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int TAG_W = AW - LANE_BITS;

   state_e            state_q, state_d;
   logic [IW-1:0]     rr_q, rr_d;
   logic [IW-1:0]     gnt_q, gnt_d;
   logic [NCH-1:0]    gnt_oh_q, gnt_oh_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [TW-1:0]     tmo_q, tmo_d;
   logic              err_q, err_d;
   logic [AW-1:0]     ddr_addr_q, ddr_addr_d;
   logic [NCH-1:0]    valid_q, valid_d;
   logic [LINE_W-1:0] line_q [NCH];
   logic [TAG_W-1:0]  tag_q  [NCH];
   logic              fill_en;

   logic [NCH-1:0]    arb_gnt;
   logic [IW-1:0]     arb_idx;
   logic              arb_any;
   logic              hit;

   rr_arbiter #(.NCH(NCH), .IW(IW)) u_rr (
      .req_i (I_REQ),
      .ptr_i (rr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign hit = valid_q[gnt_q] && (tag_q[gnt_q] == addr_q[AW-1:LANE_BITS]);

   // Next-state and output decode; outputs are pure functions of registered state
   // except the DDR strobe, which must react to this cycle's busy.
   always_comb begin
      state_d    = state_q;
      rr_d       = rr_q;
      gnt_d      = gnt_q;
      gnt_oh_d   = gnt_oh_q;
      addr_d     = addr_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      ddr_addr_d = ddr_addr_q;
      valid_d    = valid_q;
      fill_en    = 1'b0;
      O_ACK      = '0;
      O_DATA     = 8'h00;
      O_ERR      = 1'b0;
      O_DDR_RD   = 1'b0;
      O_DDR_ADDR = ddr_addr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arb_any) begin
               gnt_d    = arb_idx;
               gnt_oh_d = arb_gnt;
               addr_d   = I_ADDR[arb_idx*AW +: AW];
               err_d    = 1'b0;
               state_d  = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            state_d = hit ? ST_RESP : ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!I_DDR_BUSY) begin
               O_DDR_RD   = 1'b1;
               ddr_addr_d = {addr_q[AW-1:LANE_BITS], {LANE_BITS{1'b0}}};
               O_DDR_ADDR = ddr_addr_d;
               tmo_d      = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (I_DDR_DOUT_READY) begin
               fill_en        = 1'b1;
               valid_d[gnt_q] = 1'b1;
               state_d        = ST_RESP;
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
               err_d          = 1'b1;
               valid_d[gnt_q] = 1'b0;
               state_d        = ST_RESP;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_RESP: begin
            O_ACK   = gnt_oh_q;
            O_DATA  = err_q ? 8'h00 : lane_sel(line_q[gnt_q], addr_q[LANE_BITS-1:0]);
            O_ERR   = err_q;
            rr_d    = (gnt_q == IW'(NCH - 1)) ? '0 : gnt_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A flush wins over a same-cycle fill: the data is still returned but not kept.
      if (I_FLUSH) valid_d = '0;
   end

   // Control state with asynchronous reset.
   always_ff @(posedge I_CLK or negedge I_RSTn) begin
      if (!I_RSTn) begin
         state_q    <= ST_IDLE;
         rr_q       <= '0;
         gnt_q      <= '0;
         gnt_oh_q   <= '0;
         tmo_q      <= '0;
         err_q      <= 1'b0;
         ddr_addr_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         rr_q       <= rr_d;
         gnt_q      <= gnt_d;
         gnt_oh_q   <= gnt_oh_d;
         tmo_q      <= tmo_d;
         err_q      <= err_d;
         ddr_addr_q <= ddr_addr_d;
         valid_q    <= valid_d;
      end
   end

   // Datapath registers: latched address plus line/tag storage, qualified by valid.
   always_ff @(posedge I_CLK) begin
      addr_q <= addr_d;
      if (fill_en) begin
         line_q[gnt_q] <= I_DDR_DOUT;
         tag_q[gnt_q]  <= addr_q[AW-1:LANE_BITS];
      end
   end

endmodule
